// File: rtl/lfsr_arb_if.sv
// ---------------------------------------------------------------------------
// lfsr_arb_if
//
// Bundles the request/grant and random-data signals of lfsr_arb.
//
// Handshake: a requester raises req[i] and holds it until it sees gnt[i].
// gnt is one-hot and lasts one cycle per delivered word. rnd_valid equals
// |gnt and qualifies rnd_data in that same cycle. There is no backpressure:
// a word is consumed on the cycle it is presented.
//
// Signals:
//   seed_in    [15:0]  seed value used by seed_load
//   seed_load          load seed_in into the LFSR this cycle
//   enable             permits grants / stepping
//   req        [N-1:0] per-requester level request
//   gnt        [N-1:0] one-hot registered grant
//   rnd_valid          high while a word is delivered (|gnt)
//   rnd_data   [15:0]  word delivered with gnt
//   wrap               one-cycle pulse when the sequence returns to the seed
//   busy               high in RUN or WRAP
//   dbg_state  [1:0]   controller state (0 IDLE, 1 RUN, 2 WRAP)
//
// Modports: master = consumer/driver side, slave = lfsr_arb side.
// ---------------------------------------------------------------------------
interface lfsr_arb_if #(
    parameter int N = 4
);
    logic [15:0]  seed_in;
    logic         seed_load;
    logic         enable;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         rnd_valid;
    logic [15:0]  rnd_data;
    logic         wrap;
    logic         busy;
    logic [1:0]   dbg_state;

    modport master (
        output seed_in, seed_load, enable, req,
        input  gnt, rnd_valid, rnd_data, wrap, busy, dbg_state
    );

    modport slave (
        input  seed_in, seed_load, enable, req,
        output gnt, rnd_valid, rnd_data, wrap, busy, dbg_state
    );
endinterface

// File: rtl/lfsr_arb.sv
// ---------------------------------------------------------------------------
// lfsr_arb
//
// Shares one 16-bit maximal-length Fibonacci LFSR (taps 16,14,13,11) among
// N requesters. Requests are served round-robin, one word per grant, with a
// one-cycle latency from the sampled request to the registered grant. The
// controller counts steps since the last seed load and, after 65535 steps
// (one full period), inserts a single bubble cycle and pulses wrap.
//
// Parameters:
//   N             number of requesters (2..8)
//   SEED_DEFAULT  LFSR and seed register value after reset
//
// Ports:
//   clk    system clock, everything on the rising edge
//   reset  synchronous, active-high reset
//   bus    lfsr_arb_if.slave (seed/enable/req in, gnt/data/wrap/busy out)
//
// Optional feature (macro LFSR_FREERUN_EN):
//   defined   - in RUN the LFSR and step counter advance on every enabled
//               cycle; a grant returns the current pre-step value.
//   undefined - the LFSR and step counter advance only on a grant.
// ---------------------------------------------------------------------------
module lfsr_arb #(
    parameter int          N            = 4,
    parameter logic [15:0] SEED_DEFAULT = 16'h3C28
) (
    input  logic      clk,
    input  logic      reset,
    lfsr_arb_if.slave bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // Step counter value just before the step that completes a period.
    localparam logic [15:0] LAST_STEP = 16'hFFFE;
    localparam logic [N-1:0] ONE_HOT0 = N'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WRAP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [15:0]     lfsr;
    logic [15:0]     seed_reg;
    logic [15:0]     step_cnt;
    logic [PW-1:0]   rr_ptr;
    logic [N-1:0]    gnt_q;
    logic [15:0]     rnd_data_q;
    logic            wrap_q;

    logic [15:0]     lfsr_nxt;
    logic [15:0]     seed_eff;
    logic [PW-1:0]   winner;
    logic            any_req;
    logic            do_grant;
    logic            do_step;
    logic            period_end;
    logic            wrap_set;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // The all-zero state is a lock-up state for an XOR LFSR.
    assign seed_eff = (bus.seed_in == 16'h0000) ? 16'h0001 : bus.seed_in;

    // Circular scan starting at rr_ptr: first asserted request wins.
    always_comb begin
        int idx;
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_req && bus.req[PW'(idx)]) begin
                any_req = 1'b1;
                winner  = PW'(idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Controller FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Controller FSM: next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_step   = 1'b0;

        if (bus.seed_load) begin
            // A seed load overrides every other decision this cycle,
            // including the WRAP bubble.
            state_nxt = bus.enable ? RUN : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (!bus.enable) begin
                        state_nxt = IDLE;
                    end else begin
                        do_grant = any_req;
`ifdef LFSR_FREERUN_EN
                        do_step  = 1'b1;
`else
                        do_step  = any_req;
`endif
                        if (do_step && (step_cnt == LAST_STEP)) begin
                            state_nxt = WRAP;
                        end
                    end
                end
                WRAP: begin
                    state_nxt = bus.enable ? RUN : IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign period_end = do_step && (step_cnt == LAST_STEP);

    // wrap is raised one cycle after entering WRAP, so it never overlaps
    // the grant of the period's final word (which is visible during WRAP).
    assign wrap_set = (state == WRAP) && !bus.seed_load;

    // ------------------------------------------------------------------
    // LFSR, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr       <= SEED_DEFAULT;
            seed_reg   <= SEED_DEFAULT;
            step_cnt   <= 16'h0000;
            rr_ptr     <= '0;
            gnt_q      <= '0;
            rnd_data_q <= 16'h0000;
            wrap_q     <= 1'b0;
        end else begin
            wrap_q <= wrap_set;
            gnt_q  <= do_grant ? (ONE_HOT0 << winner) : '0;

            if (bus.seed_load) begin
                lfsr     <= seed_eff;
                seed_reg <= seed_eff;
                step_cnt <= 16'h0000;
            end else if (do_step) begin
                if (period_end) begin
                    // After a full period the next value is the seed;
                    // reloading it keeps the register tied to the seed.
                    lfsr     <= seed_reg;
                    step_cnt <= 16'h0000;
                end else begin
                    lfsr     <= lfsr_nxt;
                    step_cnt <= step_cnt + 16'h0001;
                end
            end

            if (do_grant) begin
                rnd_data_q <= lfsr;
                rr_ptr     <= (winner == PW'(N - 1)) ? '0 : winner + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.gnt       = gnt_q;
    assign bus.rnd_valid = |gnt_q;
    assign bus.rnd_data  = rnd_data_q;
    assign bus.wrap      = wrap_q;
    assign bus.busy      = (state == RUN) || (state == WRAP);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_lfsr_arb.sv
// ---------------------------------------------------------------------------
// tb_lfsr_arb
//
// Bench for lfsr_arb with N=4: a table of single-cycle vectors, then a full
// period run to the wrap bubble, then an idle-RUN sequence whose expected
// word depends on LFSR_FREERUN_EN.
// ---------------------------------------------------------------------------
module tb_lfsr_arb;

    localparam int N = 4;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    lfsr_arb_if #(.N(N)) bus ();

    lfsr_arb #(.N(N), .SEED_DEFAULT(16'h3C28)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [3:0]  gnt;
        logic        valid;
        logic [15:0] data;
        logic        wrap;
        logic        busy;
    } exp_t;

    logic [22:0] exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input string tag,
                       input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%s]: got %h, expected %h", name, tag, act, exp);
        end
    endtask

    // Reference LFSR step, written from the polynomial.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // ------------------------------------------------------------------
    // Driver: apply one cycle of inputs, queue the outputs expected after
    // the next rising edge, then pop and compare them.
    // ------------------------------------------------------------------
    task automatic cycle(input logic rst, input logic sl, input logic [15:0] seed,
                         input logic en, input logic [3:0] rq,
                         input logic [3:0] e_gnt, input logic [15:0] e_data,
                         input logic e_wrap, input logic e_busy,
                         input string tag);
        exp_t e;
        exp_t got;
        reset         = rst;
        bus.seed_load = sl;
        bus.seed_in   = seed;
        bus.enable    = en;
        bus.req       = rq;
        e.gnt   = e_gnt;
        e.valid = (e_gnt != 4'b0000);
        e.data  = e_data;
        e.wrap  = e_wrap;
        e.busy  = e_busy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard [%s]: got empty queue, expected an entry", tag);
        end else begin
            e = exp_t'(exp_q.pop_front());
            got.gnt   = bus.gnt;
            got.valid = bus.rnd_valid;
            got.data  = bus.rnd_data;
            got.wrap  = bus.wrap;
            got.busy  = bus.busy;
            chk("gnt",       tag, {12'h000, got.gnt},   {12'h000, e.gnt});
            chk("rnd_valid", tag, {15'h0000, got.valid}, {15'h0000, e.valid});
            chk("rnd_data",  tag, got.data,              e.data);
            chk("wrap",      tag, {15'h0000, got.wrap},  {15'h0000, e.wrap});
            chk("busy",      tag, {15'h0000, got.busy},  {15'h0000, e.busy});
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        rst;
        logic        sl;
        logic [15:0] seed;
        logic        en;
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [15:0] data;
        logic        wrap;
        logic        busy;
    } vec_t;

    localparam int NV = 33;
    vec_t vec [NV];

    initial begin
        logic [15:0] m;
        logic [15:0] last;

        bus.seed_in   = 16'h0000;
        bus.seed_load = 1'b0;
        bus.enable    = 1'b0;
        bus.req       = 4'b0000;

        //            rst   sl    seed      en    req      gnt      data      wrap  busy
        // Reset state, then single requester stream.
        vec[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0};
        vec[1]  = '{1'b0, 1'b1, 16'h3C28, 1'b1, 4'b0001, 4'b0000, 16'h0000, 1'b0, 1'b1};
        vec[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'h3C28, 1'b0, 1'b1};
        vec[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'h7851, 1'b0, 1'b1};
        vec[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'hF0A2, 1'b0, 1'b1};
        // Round-robin over three requesters, index 3 never requests.
        vec[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'b0111, 4'b0000, 16'h0000, 1'b0, 1'b0};
        vec[6]  = '{1'b0, 1'b1, 16'h3C28, 1'b1, 4'b0111, 4'b0000, 16'h0000, 1'b0, 1'b1};
        vec[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0111, 4'b0001, 16'h3C28, 1'b0, 1'b1};
        vec[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0111, 4'b0010, 16'h7851, 1'b0, 1'b1};
        vec[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0111, 4'b0100, 16'hF0A2, 1'b0, 1'b1};
        vec[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0111, 4'b0001, 16'hE145, 1'b0, 1'b1};
        vec[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0111, 4'b0010, 16'hC28A, 1'b0, 1'b1};
        // Zero seed is replaced by 0001; rnd_data holds during the load.
        vec[12] = '{1'b0, 1'b1, 16'h0000, 1'b1, 4'b0001, 4'b0000, 16'hC28A, 1'b0, 1'b1};
        vec[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'h0001, 1'b0, 1'b1};
        vec[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'h0002, 1'b0, 1'b1};
        vec[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'h0004, 1'b0, 1'b1};
        // Enable dropped for three cycles, LFSR frozen, then resumes.
        vec[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'b0001, 4'b0000, 16'h0004, 1'b0, 1'b0};
        vec[17] = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'b0001, 4'b0000, 16'h0004, 1'b0, 1'b0};
        vec[18] = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'b0001, 4'b0000, 16'h0004, 1'b0, 1'b0};
        vec[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0000, 16'h0004, 1'b0, 1'b1};
        vec[20] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'h0008, 1'b0, 1'b1};
        // Seed load together with a request: no grant, new seed served first.
        vec[21] = '{1'b0, 1'b1, 16'h1234, 1'b1, 4'b0001, 4'b0000, 16'h0008, 1'b0, 1'b1};
        vec[22] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'h1234, 1'b0, 1'b1};
        vec[23] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'h2469, 1'b0, 1'b1};
        // Reset mid-stream returns the LFSR to SEED_DEFAULT.
        vec[24] = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0000, 16'h0000, 1'b0, 1'b0};
        vec[25] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0000, 16'h0000, 1'b0, 1'b1};
        vec[26] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'h3C28, 1'b0, 1'b1};
        // Reset dominates seed_load.
        vec[27] = '{1'b1, 1'b1, 16'h5555, 1'b1, 4'b1000, 4'b0000, 16'h0000, 1'b0, 1'b0};
        vec[28] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b1000, 4'b0000, 16'h0000, 1'b0, 1'b1};
        vec[29] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b1000, 4'b1000, 16'h3C28, 1'b0, 1'b1};
        // Seed load with enable low goes to IDLE.
        vec[30] = '{1'b0, 1'b1, 16'hABCD, 1'b0, 4'b1000, 4'b0000, 16'h3C28, 1'b0, 1'b0};
        vec[31] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b1000, 4'b0000, 16'h3C28, 1'b0, 1'b1};
        vec[32] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b1000, 4'b1000, 16'hABCD, 1'b0, 1'b1};

        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            cycle(vec[i].rst, vec[i].sl, vec[i].seed, vec[i].en, vec[i].req,
                  vec[i].gnt, vec[i].data, vec[i].wrap, vec[i].busy,
                  $sformatf("vec%0d", i));
        end

        // Full period: 65535 grants, then one bubble with wrap, then the
        // seed comes out again.
        cycle(1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0, "wrap_rst");
        cycle(1'b0, 1'b1, 16'h3C28, 1'b1, 4'b0001, 4'b0000, 16'h0000, 1'b0, 1'b1, "wrap_seed");
        m    = 16'h3C28;
        last = 16'h3C28;
        for (int k = 0; k < 65535; k++) begin
            cycle(1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, m, 1'b0, 1'b1, "period");
            last = m;
            m    = lfsr_step(m);
        end
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0000, last,     1'b1, 1'b1, "wrap_bubble");
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'h3C28, 1'b0, 1'b1, "wrap_reseed");
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'h7851, 1'b0, 1'b1, "wrap_next");

        // Two RUN cycles without requests, then one request.
        cycle(1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0, "idle_rst");
        cycle(1'b0, 1'b1, 16'h3C28, 1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b1, "idle_seed");
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b1, "idle_noreq0");
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b1, "idle_noreq1");
`ifdef LFSR_FREERUN_EN
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'hF0A2, 1'b0, 1'b1, "freerun_word");
`else
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 4'b0001, 4'b0001, 16'h3C28, 1'b0, 1'b1, "held_word");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
